tag_reorder_buffer: RTL

- Parametrised in-order collector for out-of-order tagged results from LANES parallel producers (dividers, normalisers).
- Each lane writes into its own small FIFO.
- A tag matcher pops the lane whose head carries expected_tag and forwards it through a registered valid/ready output stage.
- Sits between the divider array and the downstream ray-direction consumer.
- Successor to the fixed 16-lane, depth-2 collector: adds backpressure, configurable lane count, depth and payload width, and error reporting.

---
 rtl/tag_reorder_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/tag_reorder_buffer.sv
// tag_reorder_buffer: collects out-of-order tagged results from parallel lanes and emits them in tag order.
// Optional feature macro: REORDER_TIMEOUT_EN (skip a missing tag after TIMEOUT_CYCLES stalled cycles).
// Ports:
//   clk            clock
//   reset_i        synchronous active-high reset
//   in_valid_i     per-lane write strobe
//   in_tag_i       packed per-lane tags, lane i at [i*TAG_SIZE +: TAG_SIZE]
//   in_data_i      packed per-lane payloads, lane i at [i*DATA_W +: DATA_W]
//   in_ready_o     per-lane FIFO not full
//   out_valid_o    output stage holds the in-order entry
//   out_ready_i    consumer accepts the output entry
//   out_tag_o      tag of the output entry
//   out_data_o     payload of the output entry
//   expected_tag_o next tag to be emitted
//   overflow_err_o sticky, a write hit a full lane
//   dup_err_o      sticky, more than one lane head matched expected_tag
//   skip_out_o     one-cycle pulse, a tag was skipped on timeout
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif
module tag_reorder_buffer #(
   parameter int LANES          = 16,
   parameter int LANE_DEPTH     = 4,
   parameter int TAG_SIZE       = `TAG_SIZE,
   parameter int DATA_W         = 96,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clk,
   input  logic                      reset_i,
   input  logic [LANES-1:0]          in_valid_i,
   input  logic [LANES*TAG_SIZE-1:0] in_tag_i,
   input  logic [LANES*DATA_W-1:0]   in_data_i,
   output logic [LANES-1:0]          in_ready_o,
   output logic                      out_valid_o,
   input  logic                      out_ready_i,
   output logic [TAG_SIZE-1:0]       out_tag_o,
   output logic [DATA_W-1:0]         out_data_o,
   output logic [TAG_SIZE-1:0]       expected_tag_o,
   output logic                      overflow_err_o,
   output logic                      dup_err_o,
   output logic                      skip_out_o
);
   localparam int PW = $clog2(LANE_DEPTH);
   localparam int CW = $clog2(LANE_DEPTH + 1);
   localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
   logic [LANES-1:0]    empty, match, push, pop;
   logic [TAG_SIZE-1:0] head_tag [LANES];
   logic [DATA_W-1:0]   head_data [LANES];
   logic [LW-1:0]       sel;
   logic                free, load, multi, expire;
   logic                out_valid_q, out_valid_d, ovf_q, ovf_d, dup_q, dup_d, skip_q;
   logic [TAG_SIZE-1:0] exp_q, exp_d, out_tag_q, out_tag_d;
   logic [DATA_W-1:0]   out_data_q, out_data_d;
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [TAG_SIZE-1:0] tag_q [LANE_DEPTH];
      logic [DATA_W-1:0]   data_q [LANE_DEPTH];
      logic [PW-1:0]       rd_q, wr_q;
      logic [CW-1:0]       cnt_q;
      // Readiness uses the pre-pop count, so a same-cycle pop never frees a slot early.
      assign in_ready_o[i] = cnt_q < CW'(LANE_DEPTH);
      assign empty[i]      = cnt_q == '0;
      assign head_tag[i]   = tag_q[rd_q];
      assign head_data[i]  = data_q[rd_q];
      assign match[i]      = !empty[i] && head_tag[i] == exp_q;
      assign push[i]       = in_valid_i[i] && in_ready_o[i];
      assign pop[i]        = load && sel == LW'(i);
      always_ff @(posedge clk)
         if (push[i]) begin
            tag_q[wr_q]  <= in_tag_i[i*TAG_SIZE +: TAG_SIZE];
            data_q[wr_q] <= in_data_i[i*DATA_W +: DATA_W];
         end
      always_ff @(posedge clk)
         if (reset_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
         end else begin
            wr_q  <= wr_q + PW'(push[i]);
            rd_q  <= rd_q + PW'(pop[i]);
            cnt_q <= cnt_q + CW'(push[i]) - CW'(pop[i]);
         end
   end
   // Descending scan leaves the lowest matching lane selected.
   always_comb begin
      sel = '0;
      for (int i = LANES - 1; i >= 0; i--)
         if (match[i]) sel = LW'(i);
   end
   // Clearing the lowest set bit leaves something only when two or more heads match.
   assign multi = (match & (match - 1'b1)) != '0;
   assign free  = !out_valid_q || out_ready_i;
   assign load  = |match && free;
`ifdef REORDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_q, tmo_d;
   logic          stall;
   assign stall  = !(&empty) && !(|match) && free;
   assign expire = stall && tmo_q == TW'(TIMEOUT_CYCLES - 1);
   assign tmo_d  = (load || &empty || expire) ? '0 : stall ? tmo_q + 1'b1 : tmo_q;
   always_ff @(posedge clk)
      if (reset_i) tmo_q <= '0;
      else tmo_q <= tmo_d;
`else
   assign expire = 1'b0;
`endif
   always_comb begin
      out_valid_d = load ? 1'b1 : out_ready_i ? 1'b0 : out_valid_q;
      out_tag_d   = load ? head_tag[sel] : out_tag_q;
      out_data_d  = load ? head_data[sel] : out_data_q;
      exp_d       = exp_q + TAG_SIZE'(load || expire);
      ovf_d       = ovf_q || |(in_valid_i & ~in_ready_o);
      dup_d       = dup_q || multi;
   end
   always_ff @(posedge clk)
      if (reset_i) begin
         out_valid_q <= 1'b0;
         out_tag_q   <= '0;
         out_data_q  <= '0;
         exp_q       <= '0;
         ovf_q       <= 1'b0;
         dup_q       <= 1'b0;
         skip_q      <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_tag_q   <= out_tag_d;
         out_data_q  <= out_data_d;
         exp_q       <= exp_d;
         ovf_q       <= ovf_d;
         dup_q       <= dup_d;
         skip_q      <= expire;
      end
   assign out_valid_o    = out_valid_q;
   assign out_tag_o      = out_tag_q;
   assign out_data_o     = out_data_q;
   assign expected_tag_o = exp_q;
   assign overflow_err_o = ovf_q;
   assign dup_err_o      = dup_q;
   assign skip_out_o     = skip_q;
endmodule
